demux1x4_stream: RTL and testbench
==================================

Name: demux1x4_stream

Overview:
- Inverse of the team's parameterised 4:1 bus mux: steers one N-bit input stream to one of four N-bit output channels, chosen per word by a 2-bit select.
- Each output channel has a one-entry registered slot with a valid/ready handshake, so backpressure on one channel does not block words going to the other channels.
- Each channel counts the words it has delivered, for debug and bandwidth observation.
- Sits between a single producer and four independent consumers on the same clock.

Parameters:
N, 8, data bus width in bits (N >= 1)
CW, 8, width of each per-channel delivered-word counter (CW >= 1)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
in_data  input  N  input word
in_sel  input  2  destination channel for in_data: 0..3 -> out0..out3
in_valid  input  1  producer has a word on in_data/in_sel
in_ready  output  1  block accepts the word this cycle (combinational)
out0  output  N  channel 0 slot data (registered)
out1  output  N  channel 1 slot data (registered)
out2  output  N  channel 2 slot data (registered)
out3  output  N  channel 3 slot data (registered)
out_valid  output  4  bit k: channel k slot holds a word
out_ready  input  4  bit k: consumer k takes the word this cycle
cnt0  output  CW  words delivered on channel 0
cnt1  output  CW  words delivered on channel 1
cnt2  output  CW  words delivered on channel 2
cnt3  output  CW  words delivered on channel 3
busy  output  1  OR of out_valid

Behaviour:
- Reset (rst_n low, takes effect asynchronously):
  - out_valid = 4'b0000; out0..out3 = {N{1'b0}}; cnt0..cnt3 = 0.
  - Pending slot contents are discarded, including on reset mid-stream.
  - busy = 0.
- Per-channel slot, 2 states:
  - EMPTY (out_valid[k] = 0) and FULL (out_valid[k] = 1).
- in_ready = !out_valid[in_sel] | out_ready[in_sel].
  - Purely combinational from in_sel, out_valid and out_ready; never depends on in_valid.
  - in_ready is valid whatever in_sel is; in_sel and in_data are don't-care when in_valid = 0.
- Accept (in_valid & in_ready):
  - Slot in_sel loads in_data at the clock edge.
  - out_valid[in_sel] = 1 from the next cycle. Latency: 1 cycle from accept to out_valid.
  - At most one channel loads per cycle.
- Deliver on channel k (out_valid[k] & out_ready[k]):
  - Word is consumed at the edge; cnt_k increments by 1, modulo 2^CW.
  - Wrap-around: all-ones -> 0, with no flag.
- Simultaneous deliver and accept on the same channel:
  - Slot takes the new word and out_valid[k] stays 1.
  - Full throughput of 1 word/cycle on one channel while its consumer is ready.
- Deliver on channel k and accept on channel j (j != k) in the same cycle:
  - Both happen independently.
  - Slot k goes EMPTY; slot j goes FULL.
- Stall: while out_valid[k] & !out_ready[k], outk and out_valid[k] hold stable.
- out_ready[k] while slot k is EMPTY: ignored; no count change.
- out_ready bits for non-selected channels have no effect on in_ready.
- Data of an EMPTY slot keeps its last value; consumers use it only when out_valid[k] = 1.
- Ordering:
  - Words to the same channel are delivered in acceptance order.
  - There is no ordering guarantee between channels.
- busy = |out_valid, registered-equivalent (derived only from slot state).

Test Plan:
- Reset then idle: rst_n low mid-run with slots FULL -> out_valid = 0, outs = 0, cnts = 0, in_ready = 1 for every in_sel.
- Single route, N=8: in_sel = 2, in_data = 8'hA5, in_valid = 1, out_ready = 0 -> next cycle out_valid = 4'b0100, out2 = 8'hA5; with in_sel = 2 held, in_ready = 0; with in_sel = 0, in_ready = 1.
- Streaming: in_sel = 1, out_ready[1] = 1, send 8'h01..8'h10 back to back -> out1 shows 8'h01..8'h10 on consecutive cycles, one per cycle after 1-cycle latency; in_ready stays 1; cnt1 = 16.
- Backpressure isolation: fill channel 3 with 8'h3C, out_ready[3] = 0 for 5 cycles, meanwhile send 8'h11 to channel 0 -> out3 stable at 8'h3C for all 5 cycles; channel 0 delivers 8'h11; cnt0 = 1, cnt3 = 0.
- Simultaneous events: channel 2 FULL with out_ready[2] = 1 while accepting 8'h77 to channel 2 -> out_valid[2] stays 1, out2 = 8'h77, cnt2 +1.
- Counter wrap, CW=4: deliver 17 words on channel 0 -> cnt0 reads 15 after 15 words, 0 after 16, 1 after 17.

Source files
------------

// File: rtl/demux1x4_stream.sv
// demux1x4_stream: routes one N-bit input stream to one of four output channels.
// Each channel has a one-word registered slot with a valid/ready handshake, so a
// stalled consumer only blocks words addressed to its own channel. Each channel
// also counts the words it has delivered.
module demux1x4_stream #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in_data,
  input  logic [1:0]    in_sel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  out0,
  output logic [N-1:0]  out1,
  output logic [N-1:0]  out2,
  output logic [N-1:0]  out3,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic [CW-1:0] cnt3,
  output logic          busy
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  slot_state_e   slotState_q [4];
  slot_state_e   slotState_d [4];
  logic [N-1:0]  slotData_q  [4];
  logic [N-1:0]  slotData_d  [4];
  logic [CW-1:0] delivCnt_q  [4];
  logic [CW-1:0] delivCnt_d  [4];
  logic          accept;

  // A slot presents valid data exactly when it is FULL.
  always_comb begin
    out_valid = '0;
    for (int k = 0; k < 4; k++) begin
      out_valid[k] = (slotState_q[k] == SLOT_FULL);
    end
  end

  // The selected slot can take a word if it is empty or is being drained this cycle.
  assign in_ready = !out_valid[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;

  // Per-slot next state: a load wins over a drain so back-to-back streaming keeps the slot FULL.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      slotState_d[k] = slotState_q[k];
      slotData_d[k]  = slotData_q[k];
      delivCnt_d[k]  = delivCnt_q[k];
      if (out_valid[k] && out_ready[k]) begin
        delivCnt_d[k] = delivCnt_q[k] + CW'(1);
      end
      case (slotState_q[k])
        SLOT_EMPTY: begin
          if (accept && (in_sel == 2'(k))) begin
            slotState_d[k] = SLOT_FULL;
            slotData_d[k]  = in_data;
          end
        end
        SLOT_FULL: begin
          if (accept && (in_sel == 2'(k))) begin
            slotState_d[k] = SLOT_FULL;
            slotData_d[k]  = in_data;
          end else if (out_ready[k]) begin
            slotState_d[k] = SLOT_EMPTY;
          end
        end
        default: slotState_d[k] = SLOT_EMPTY;
      endcase
    end
  end

  // Slot state, data and counters; reset discards any pending words immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        slotState_q[k] <= SLOT_EMPTY;
        slotData_q[k]  <= '0;
        delivCnt_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        slotState_q[k] <= slotState_d[k];
        slotData_q[k]  <= slotData_d[k];
        delivCnt_q[k]  <= delivCnt_d[k];
      end
    end
  end

  assign out0 = slotData_q[0];
  assign out1 = slotData_q[1];
  assign out2 = slotData_q[2];
  assign out3 = slotData_q[3];
  assign cnt0 = delivCnt_q[0];
  assign cnt1 = delivCnt_q[1];
  assign cnt2 = delivCnt_q[2];
  assign cnt3 = delivCnt_q[3];
  assign busy = |out_valid;

endmodule

// File: tb/tb_demux1x4_stream.sv
// tb_demux1x4_stream: self-checking bench for demux1x4_stream (N=8, CW=4).
module tb_demux1x4_stream;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  in_data = '0;
  logic [1:0]    in_sel = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  out0, out1, out2, out3;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready = '0;
  logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;
  logic          busy;

  demux1x4_stream #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out_valid(out_valid), .out_ready(out_ready),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3),
    .busy(busy)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
  } sbEntry_t;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    logic       valid;
    logic [3:0] ready;
    logic       expReady;
    logic [3:0] expValid;
    logic [7:0] expOut2;
  } vec_t;

  sbEntry_t      sbQ[$];
  logic [3:0]    mValid = '0;
  logic [CW-1:0] mCnt [4] = '{default: '0};
  int            checks = 0;
  int            fails = 0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] getOut(input int k);
    case (k)
      0: return out0;
      1: return out1;
      2: return out2;
      default: return out3;
    endcase
  endfunction

  function automatic logic [CW-1:0] getCnt(input int k);
    case (k)
      0: return cnt0;
      1: return cnt1;
      2: return cnt2;
      default: return cnt3;
    endcase
  endfunction

  function automatic int findHead(input int ch);
    foreach (sbQ[i]) begin
      if (sbQ[i].ch == 2'(ch)) return i;
    end
    return -1;
  endfunction

  task automatic driveInputs(input logic [1:0] sel, input logic [7:0] data,
                             input logic valid, input logic [3:0] ready);
    @(negedge clk);
    in_sel    = sel;
    in_data   = data;
    in_valid  = valid;
    out_ready = ready;
    #1;
  endtask

  // Compare against model/scoreboard, update the model for this cycle, then advance past the edge.
  task automatic checkOutput();
    logic expRdy;
    int   idx;
    expRdy = !mValid[in_sel] | out_ready[in_sel];
    checkVal("in_ready", 32'(in_ready), 32'(expRdy));
    checkVal("out_valid", 32'(out_valid), 32'(mValid));
    checkVal("busy", 32'(busy), 32'(|mValid));
    for (int k = 0; k < 4; k++) begin
      checkVal($sformatf("cnt%0d", k), 32'(getCnt(k)), 32'(mCnt[k]));
      if (mValid[k]) begin
        idx = findHead(k);
        if (idx < 0) begin
          checkVal($sformatf("sb_missing%0d", k), 32'(1), 32'(0));
        end else begin
          checkVal($sformatf("out%0d", k), 32'(getOut(k)), 32'(sbQ[idx].data));
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (mValid[k] && out_ready[k]) begin
        mCnt[k]   = mCnt[k] + CW'(1);
        mValid[k] = 1'b0;
        idx = findHead(k);
        if (idx >= 0) sbQ.delete(idx);
      end
    end
    if (in_valid && expRdy) begin
      mValid[in_sel] = 1'b1;
      sbQ.push_back('{ch: in_sel, data: in_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input logic [7:0] data,
                               input logic valid, input logic [3:0] ready);
    driveInputs(sel, data, valid, ready);
    checkOutput();
  endtask

  // Asynchronous reset between clock edges, with all reset values checked before any edge.
  task automatic doReset();
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = '0;
    #1;
    checkVal("rst_out_valid", 32'(out_valid), 32'(0));
    checkVal("rst_busy", 32'(busy), 32'(0));
    for (int k = 0; k < 4; k++) begin
      checkVal($sformatf("rst_out%0d", k), 32'(getOut(k)), 32'(0));
      checkVal($sformatf("rst_cnt%0d", k), 32'(getCnt(k)), 32'(0));
      in_sel = 2'(k);
      #1;
      checkVal($sformatf("rst_in_ready_sel%0d", k), 32'(in_ready), 32'(1));
    end
    mValid = '0;
    for (int k = 0; k < 4; k++) mCnt[k] = '0;
    sbQ.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs [7];

  initial begin
    // Single route to channel 2, selection-dependent in_ready, simultaneous drain+load.
    vecs[0] = '{2'd2, 8'hA5, 1'b1, 4'b0000, 1'b1, 4'b0000, 8'h00};
    vecs[1] = '{2'd2, 8'h00, 1'b0, 4'b0000, 1'b0, 4'b0100, 8'hA5};
    vecs[2] = '{2'd0, 8'h00, 1'b0, 4'b0000, 1'b1, 4'b0100, 8'hA5};
    vecs[3] = '{2'd2, 8'h77, 1'b1, 4'b0100, 1'b1, 4'b0100, 8'hA5};
    vecs[4] = '{2'd2, 8'h00, 1'b0, 4'b0000, 1'b0, 4'b0100, 8'h77};
    vecs[5] = '{2'd1, 8'h00, 1'b0, 4'b0100, 1'b1, 4'b0100, 8'h77};
    vecs[6] = '{2'd3, 8'h00, 1'b0, 4'b0000, 1'b1, 4'b0000, 8'h77};

    doReset();

    for (int i = 0; i < 7; i++) begin
      driveInputs(vecs[i].sel, vecs[i].data, vecs[i].valid, vecs[i].ready);
      checkVal($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].expReady));
      checkVal($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].expValid));
      checkVal($sformatf("vec%0d_out2", i), 32'(out2), 32'(vecs[i].expOut2));
      checkOutput();
    end
    checkVal("route_cnt2", 32'(cnt2), 32'(2));

    // Fill every slot, then reset mid-stream.
    for (int k = 0; k < 4; k++) applyStimulus(2'(k), 8'(8'hC0 + k), 1'b1, 4'b0000);
    checkVal("fill_out_valid", 32'(out_valid), 32'(4'b1111));
    doReset();
    applyStimulus(2'd0, 8'h00, 1'b0, 4'b0000);

    // Streaming 16 words on channel 1; the 4-bit counter wraps back to 0.
    for (int i = 1; i <= 16; i++) applyStimulus(2'd1, 8'(i), 1'b1, 4'b0010);
    applyStimulus(2'd0, 8'h00, 1'b0, 4'b0010);
    checkVal("stream_cnt1", 32'(cnt1), 32'(0));
    checkVal("stream_drained", 32'(out_valid), 32'(0));

    // Backpressure isolation: channel 3 stalls while channel 0 delivers.
    doReset();
    applyStimulus(2'd3, 8'h3C, 1'b1, 4'b0000);
    applyStimulus(2'd0, 8'h11, 1'b1, 4'b0001);
    applyStimulus(2'd0, 8'h00, 1'b0, 4'b0001);
    for (int i = 0; i < 3; i++) applyStimulus(2'd3, 8'h00, 1'b0, 4'b0000);
    checkVal("bp_out3", 32'(out3), 32'(8'h3C));
    checkVal("bp_out_valid", 32'(out_valid), 32'(4'b1000));
    checkVal("bp_cnt0", 32'(cnt0), 32'(1));
    checkVal("bp_cnt3", 32'(cnt3), 32'(0));
    applyStimulus(2'd0, 8'h00, 1'b0, 4'b1000);
    checkVal("bp_cnt3_after", 32'(cnt3), 32'(1));

    // Counter wrap on channel 0 over 17 deliveries.
    doReset();
    for (int i = 0; i <= 16; i++) begin
      applyStimulus(2'd0, 8'(i + 1), 1'b1, 4'b0001);
      if (i == 15) checkVal("wrap_cnt0_15", 32'(cnt0), 32'(15));
      if (i == 16) checkVal("wrap_cnt0_16", 32'(cnt0), 32'(0));
    end
    applyStimulus(2'd0, 8'h00, 1'b0, 4'b0001);
    checkVal("wrap_cnt0_17", 32'(cnt0), 32'(1));

    // Ready on an empty slot must not count.
    applyStimulus(2'd0, 8'h00, 1'b0, 4'b1111);
    checkVal("idle_ready_cnt0", 32'(cnt0), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
